// File: rtl/lpddr_arbiter.sv
// lpddr_arbiter: three-requester (video, disk, cpu) arbiter in front of a
// single LPDDR memory port.  One transaction at a time through the
// IDLE -> ISSUE -> WAIT -> DONE sequence, with a bounded wait for mem_ack.
// Optional feature macro: LPDDR_ARB_ROUND_ROBIN_EN selects rotating
// priority; when undefined, priority is fixed video > disk > cpu.
module lpddr_arbiter #(
    parameter int ADDR_W         = 22,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  cpu_clk,
    input  logic                  dcm_reset,
    input  logic                  lpddr_calib_done,
    input  logic [2:0]            req,
    input  logic [2:0]            wr,
    input  logic [3*ADDR_W-1:0]   addr_in,
    input  logic [95:0]           wdata_in,
    output logic [2:0]            gnt,
    output logic [2:0]            done,
    output logic [31:0]           rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  timeout_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Counter value on the last WAIT cycle before giving up.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic                cal_meta_reg;
    logic                cal_ok_reg;
    logic [1:0]          state_reg;
    logic [1:0]          owner_reg;
    logic [9:0]          tcnt_reg;
    logic [1:0]          win_idx_next;
    logic [ADDR_W-1:0]   addr_arr [3];
    logic [31:0]         wdata_arr [3];

    // Unpack the flat per-requester buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_in[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata_in[gi*32 +: 32];
        end
    endgenerate

    // Two-flop synchronizer for the calibration-done flag.
    always_ff @(posedge cpu_clk or posedge dcm_reset) begin
        if (dcm_reset) begin
            cal_meta_reg <= 1'b0;
            cal_ok_reg   <= 1'b0;
        end else begin
            cal_meta_reg <= lpddr_calib_done;
            cal_ok_reg   <= cal_meta_reg;
        end
    end

`ifdef LPDDR_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_reg;
    logic [1:0] cand_idx [3];

    // Candidate k is the requester index k places after the pointer (mod 3).
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            logic [2:0] sum_w;
            assign sum_w        = {1'b0, ptr_reg} + 3'(gi);
            assign cand_idx[gi] = (sum_w >= 3'd3) ? 2'(sum_w - 3'd3) : sum_w[1:0];
        end
    endgenerate

    // First requesting index at or after the pointer wins; scan from the
    // farthest candidate so the nearest one overrides.
    always_comb begin
        win_idx_next = ptr_reg;
        for (int k = 2; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                win_idx_next = cand_idx[k];
            end
        end
    end

    // Pointer moves just past the owner when a transaction finishes.
    always_ff @(posedge cpu_clk or posedge dcm_reset) begin
        if (dcm_reset) begin
            ptr_reg <= 2'd0;
        end else if (state_reg == DONE) begin
            ptr_reg <= (owner_reg == 2'd2) ? 2'd0 : owner_reg + 2'd1;
        end
    end
`else
    // Fixed priority: video (0) over disk (1) over cpu (2).
    always_comb begin
        if (req[0]) begin
            win_idx_next = 2'd0;
        end else if (req[1]) begin
            win_idx_next = 2'd1;
        end else begin
            win_idx_next = 2'd2;
        end
    end
`endif

    // Transaction sequencer and all registered outputs.
    always_ff @(posedge cpu_clk or posedge dcm_reset) begin
        if (dcm_reset) begin
            state_reg   <= IDLE;
            owner_reg   <= 2'd0;
            tcnt_reg    <= 10'd0;
            gnt         <= 3'b000;
            done        <= 3'b000;
            rdata       <= 32'd0;
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 3'b000;
                    if (cal_ok_reg && (req != 3'b000)) begin
                        owner_reg <= win_idx_next;
                        gnt       <= 3'b001 << win_idx_next;
                        mem_wr    <= wr[win_idx_next];
                        mem_addr  <= addr_arr[win_idx_next];
                        mem_wdata <= wdata_arr[win_idx_next];
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req   <= 1'b1;
                    tcnt_reg  <= 10'd0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (mem_ack) begin
                        rdata     <= mem_rdata;
                        mem_req   <= 1'b0;
                        done      <= gnt;
                        state_reg <= DONE;
                    end else if (tcnt_reg == TO_LAST) begin
                        rdata       <= 32'hDEADBEEF;
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= gnt;
                        state_reg   <= DONE;
                    end else begin
                        tcnt_reg <= tcnt_reg + 10'd1;
                    end
                end
                DONE: begin
                    done      <= 3'b000;
                    gnt       <= 3'b000;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpddr_arbiter.sv
// tb_lpddr_arbiter: directed self-checking bench for lpddr_arbiter.
// Follows LPDDR_ARB_ROUND_ROBIN_EN for the expected grant order.
module tb_lpddr_arbiter;

    localparam int ADDR_W = 22;

    logic                cpu_clk = 1'b0;
    logic                dcm_reset;
    logic                lpddr_calib_done;
    logic [2:0]          req;
    logic [2:0]          wr;
    logic [3*ADDR_W-1:0] addr_in;
    logic [95:0]         wdata_in;
    logic [2:0]          gnt;
    logic [2:0]          done;
    logic [31:0]         rdata;
    logic                mem_req;
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_ack;
    logic [31:0]         mem_rdata;
    logic                timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] a_tab [3];
    logic [31:0]       d_tab [3];
    logic [2:0]        exp_order [6];

    lpddr_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
        .cpu_clk(cpu_clk), .dcm_reset(dcm_reset), .lpddr_calib_done(lpddr_calib_done),
        .req(req), .wr(wr), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt), .done(done), .rdata(rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for mem_req, check the issued request, ack after lat cycles.
    task automatic serve(input logic [2:0] exp_g, input int lat, input logic [31:0] data,
                         input logic [ADDR_W-1:0] exp_addr, input logic exp_wr,
                         input logic [31:0] exp_wd, input bit drop);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("mem_req_rise", {63'd0, mem_req}, 64'd1);
        check("gnt", {61'd0, gnt}, {61'd0, exp_g});
        check("mem_addr", {42'd0, mem_addr}, {42'd0, exp_addr});
        check("mem_wr", {63'd0, mem_wr}, {63'd0, exp_wr});
        if (exp_wr) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_wd});
        if (drop) begin
            req = 3'b000;
            lpddr_calib_done = 1'b0;
        end
        for (int i = 1; i < lat; i++) begin
            tick();
            check("addr_stable", {42'd0, mem_addr}, {42'd0, exp_addr});
            check("req_held", {63'd0, mem_req}, 64'd1);
            check("no_early_done", {61'd0, done}, 64'd0);
        end
        mem_ack = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        check("done_pulse", {61'd0, done}, {61'd0, exp_g});
        check("rdata", {32'd0, rdata}, {32'd0, data});
        check("mem_req_drop", {63'd0, mem_req}, 64'd0);
        $display("txn owner=%b addr=%h wr=%b rdata=%h", exp_g, exp_addr, exp_wr, data);
        tick();
        check("done_single", {61'd0, done}, 64'd0);
        check("gnt_clear", {61'd0, gnt}, 64'd0);
    endtask

    initial begin
        int n;
        a_tab[0] = 22'h0AAAA;  d_tab[0] = 32'hB1DE0B1D;
        a_tab[1] = 22'h15555;  d_tab[1] = 32'hD15CD15C;
        a_tab[2] = 22'h00123;  d_tab[2] = 32'hC0C0C0C0;
`ifdef LPDDR_ARB_ROUND_ROBIN_EN
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_order = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        dcm_reset = 1'b1;
        lpddr_calib_done = 1'b0;
        req = 3'b000;
        wr = 3'b010;
        addr_in = {a_tab[2], a_tab[1], a_tab[0]};
        wdata_in = {d_tab[2], d_tab[1], d_tab[0]};
        mem_ack = 1'b0;
        mem_rdata = 32'd0;

        // Reset state
        repeat (3) tick();
        check("rst_gnt", {61'd0, gnt}, 64'd0);
        check("rst_done", {61'd0, done}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_addr", {42'd0, mem_addr}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
        dcm_reset = 1'b0;

        // Calibration low blocks all grants
        req = 3'b111;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("nocal_gnt", {61'd0, gnt}, 64'd0);
            check("nocal_mem_req", {63'd0, mem_req}, 64'd0);
        end
        lpddr_calib_done = 1'b1;
        n = 0;
        while (gnt == 3'b000 && n < 3) begin
            tick();
            n++;
        end
        check("cal_first_gnt", {61'd0, gnt}, 64'd1);

        // Six back-to-back transactions with all requesters active
        for (int t = 0; t < 6; t++) begin
            int o;
            o = (exp_order[t] == 3'b001) ? 0 : (exp_order[t] == 3'b010) ? 1 : 2;
            serve(exp_order[t], 1, 32'h1000_0000 + t, a_tab[o], wr[o], d_tab[o], 1'b0);
        end

        // CPU read with two-cycle ack latency
        req = 3'b100;
        serve(3'b100, 2, 32'hCAFEF00D, 22'h00123, 1'b0, 32'd0, 1'b0);
        req = 3'b000;

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("idle_ack_mem_req", {63'd0, mem_req}, 64'd0);
        check("idle_ack_done", {61'd0, done}, 64'd0);
        check("idle_ack_gnt", {61'd0, gnt}, 64'd0);

        // Disk write: req and calibration dropped mid-transaction
        req = 3'b010;
        serve(3'b010, 3, 32'h12345678, a_tab[1], 1'b1, d_tab[1], 1'b1);
        req = 3'b001;
        repeat (6) tick();
        check("cal_low_block_gnt", {61'd0, gnt}, 64'd0);
        check("cal_low_block_req", {63'd0, mem_req}, 64'd0);
        lpddr_calib_done = 1'b1;
        serve(3'b001, 1, 32'h0BADF00D, a_tab[0], 1'b0, 32'd0, 1'b0);
        req = 3'b000;

        // Timeout with no ack
        req = 3'b001;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("to_mem_req_rise", {63'd0, mem_req}, 64'd1);
        req = 3'b000;
        n = 0;
        while (mem_req && n < 20) begin
            tick();
            n++;
        end
        check("to_wait_len", 64'(n), 64'd8);
        check("to_done", {61'd0, done}, 64'd1);
        check("to_rdata", {32'd0, rdata}, 64'hDEADBEEF);
        check("to_err_set", {63'd0, timeout_err}, 64'd1);
        tick();
        check("to_done_single", {61'd0, done}, 64'd0);
        req = 3'b100;
        serve(3'b100, 1, 32'h55AA55AA, a_tab[2], 1'b0, 32'd0, 1'b0);
        req = 3'b000;
        check("to_err_sticky", {63'd0, timeout_err}, 64'd1);

        // Reset while in WAIT
        req = 3'b010;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("rw_mem_req_rise", {63'd0, mem_req}, 64'd1);
        tick();
        dcm_reset = 1'b1;
        #1;
        check("rw_async_mem_req", {63'd0, mem_req}, 64'd0);
        check("rw_async_gnt", {61'd0, gnt}, 64'd0);
        tick();
        check("rw_no_done", {61'd0, done}, 64'd0);
        check("rw_err_clear", {63'd0, timeout_err}, 64'd0);
        #2;
        dcm_reset = 1'b0;
        serve(3'b010, 1, 32'hFEEDFACE, a_tab[1], 1'b1, d_tab[1], 1'b0);
        req = 3'b000;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lpddr_arbiter.md
LPDDR_ARBITER -- requirements
Module: lpddr_arbiter

Interface
REQ-001 Parameter: ADDR_W, 22, memory word-address width.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ack (range 1..1023).
REQ-003 cpu_clk  in  1  sole clock; all logic rising-edge.
REQ-004 dcm_reset  in  1  reset, asynchronous, active-high.
REQ-005 lpddr_calib_done  in  1  memory calibration complete; asynchronous to cpu_clk.
REQ-006 req  in  3  per-requester request: bit0 video, bit1 disk, bit2 cpu.
REQ-007 wr  in  3  per-requester write (1) / read (0).
REQ-008 addr_in  in  3*ADDR_W  per-requester address, requester i at slice [i*ADDR_W +: ADDR_W].
REQ-009 wdata_in  in  96  per-requester write data, requester i at [i*32 +: 32].
REQ-010 gnt  out  3  one-hot owner of the current transaction.
REQ-011 done  out  3  one-cycle completion pulse to the owner.
REQ-012 rdata  out  32  read data; valid in the done cycle.
REQ-013 mem_req / mem_wr  out  1 each  memory-port request and direction.
REQ-014 mem_addr  out  ADDR_W; mem_wdata  out  32; memory-port address and write data.
REQ-015 mem_ack  in  1; mem_rdata  in  32; memory-port acknowledge and read data.
REQ-016 timeout_err  out  1  sticky flag: an access timed out.

Function
REQ-017 lpddr_calib_done SHALL pass through a 2-flop synchronizer (cal_ok); no grant SHALL issue while cal_ok=0.
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE: if cal_ok and any req, select a winner, register gnt, winner's wr/addr/wdata into mem_wr/mem_addr/mem_wdata, go ISSUE next edge; else stay.
REQ-020 ISSUE: assert mem_req, clear timeout counter, go WAIT.
REQ-021 WAIT: hold mem_req and all mem_* outputs stable until mem_ack sampled high; on ack capture mem_rdata into rdata, deassert mem_req, go DONE.
REQ-022 WAIT timeout: 10-bit counter increments each WAIT cycle without ack; when it reaches TIMEOUT_CYCLES, deassert mem_req, set timeout_err, load rdata=32'hDEADBEEF, go DONE.
REQ-023 DONE: pulse done[owner] exactly one cycle, clear gnt, return IDLE; earliest next grant is the following cycle, giving a 4-cycle minimum occupancy with immediate ack.
REQ-024 A requester dropping req mid-transaction SHALL NOT abort it; done still pulses.
REQ-025 cal_ok falling mid-transaction SHALL NOT abort it; it only blocks new grants.
REQ-026 mem_ack seen in IDLE, ISSUE or DONE SHALL be ignored.
REQ-027 Only one transaction SHALL be outstanding; gnt SHALL be one-hot or zero at all times.

Reset
REQ-028 dcm_reset SHALL asynchronously force state IDLE, gnt=0, done=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, timeout_err=0, synchronizer=0, timeout counter=0, round-robin pointer=0.
REQ-029 Reset mid-transaction SHALL drop mem_req immediately without a done pulse.
REQ-030 timeout_err SHALL clear only on dcm_reset.

Configuration
REQ-031 Macro LPDDR_ARB_ROUND_ROBIN_EN: when defined, a 2-bit pointer SHALL hold the highest-priority index; after each DONE it SHALL move to (owner+1) mod 3, and the winner is the first requesting index at or after the pointer.
REQ-032 Without LPDDR_ARB_ROUND_ROBIN_EN: fixed priority video > disk > cpu, no pointer logic.

Verification
REQ-033 req=3'b111 with cal_ok low for 20 cycles -> gnt=0, mem_req=0; after calib rises, first gnt within 3 cycles, gnt=3'b001.
REQ-034 cpu read addr 22'h00123, mem_ack 2 cycles after mem_req, mem_rdata=32'hCAFEF00D -> done[2] single pulse, rdata=32'hCAFEF00D, mem_addr stable throughout.
REQ-035 req=3'b111 held for 6 transactions -> with macro, grant order 0,1,2,0,1,2; without, six grants to video.
REQ-036 mem_ack never asserted, TIMEOUT_CYCLES=8 -> mem_req drops after 8 WAIT cycles, done pulses, rdata=32'hDEADBEEF, timeout_err=1 until reset.
REQ-037 dcm_reset asserted while in WAIT -> mem_req=0 and gnt=0 asynchronously, no done pulse; after release, pending req granted normally.
